// File: rtl/duck_pixel_reader.sv
// duck_pixel_reader: sprite index ROM consumer, 16-entry palette lookup,
// background compositing and the "duck hit" white-flash effect.
// Fixed 3-cycle pipeline from DrawX/DrawY/duck_addr to pix_*.
module duck_pixel_reader #(
   parameter int unsigned FLASH_PERIOD = 4,
   parameter int unsigned FLASH_FRAMES = 32,
   parameter logic [3:0]  TRANSP_IDX   = 4'h0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        blank,
   input  logic        is_duck,
   input  logic [15:0] duck_addr,
   input  logic [23:0] bg_rgb,
   output logic [15:0] rom_addr,
   input  logic [3:0]  rom_data,
   input  logic        pal_we,
   input  logic [3:0]  pal_idx,
   input  logic [23:0] pal_data,
   input  logic        hit,
   output logic [23:0] pix_rgb,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        pix_blank,
   output logic        flashing
);

   localparam logic [5:0] PERIOD = 6'(FLASH_PERIOD);
   localparam logic [5:0] FRAMES = 6'(FLASH_FRAMES);

   typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} state_t;

   state_t      state, state_next;
   logic [5:0]  phase_cnt, total_cnt, phase_next, total_next;
   logic        frame_d, frame_edge;

   logic [23:0] palette [16];
   logic [23:0] pal_rd;

   logic        s1_valid, s1_duck, s1_blank;
   logic [9:0]  s1_x, s1_y;
   logic [23:0] s1_bg;
   logic        s2_valid, s2_duck, s2_blank;
   logic [9:0]  s2_x, s2_y;
   logic [23:0] s2_bg;
   logic [23:0] rgb_next;

   // Frame strobe rising-edge detect, registered one Clk late
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_d    <= 1'b0;
         frame_edge <= 1'b0;
      end else begin
         frame_d    <= frame_clk;
         frame_edge <= frame_clk & ~frame_d;
      end
   end

   // Flash FSM state, counters and registered flashing flag
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         phase_cnt <= '0;
         total_cnt <= '0;
         flashing  <= 1'b0;
      end else begin
         state     <= state_next;
         phase_cnt <= phase_next;
         total_cnt <= total_next;
         flashing  <= (state != IDLE);
      end
   end

   // Flash next-state: hit restarts and swallows a coincident frame edge;
   // end-of-flash wins over the on/off toggle
   always_comb begin
      state_next = state;
      phase_next = phase_cnt;
      total_next = total_cnt;
      if (hit) begin
         state_next = FLASH_ON;
         phase_next = '0;
         total_next = '0;
      end else if (frame_edge && state != IDLE) begin
         phase_next = phase_cnt + 6'd1;
         total_next = total_cnt + 6'd1;
         if (total_next == FRAMES) begin
            state_next = IDLE;
         end else if (phase_next == PERIOD) begin
            state_next = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            phase_next = '0;
         end
      end
   end

   // Palette storage; a same-cycle read sees the old entry
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < 16; i++) palette[i] <= '0;
      end else if (pal_we) begin
         palette[pal_idx] <= pal_data;
      end
   end

   assign pal_rd = palette[rom_data];

   // Stages 0-2: ROM address issue and pixel attribute delay line
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr <= '0;
         s1_valid <= 1'b0;
         s1_duck  <= 1'b0;
         s1_blank <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_bg    <= '0;
         s2_valid <= 1'b0;
         s2_duck  <= 1'b0;
         s2_blank <= 1'b0;
         s2_x     <= '0;
         s2_y     <= '0;
         s2_bg    <= '0;
      end else begin
         rom_addr <= duck_addr;
         s1_valid <= 1'b1;
         s1_duck  <= is_duck & blank;
         s1_blank <= blank;
         s1_x     <= DrawX;
         s1_y     <= DrawY;
         s1_bg    <= bg_rgb;
         s2_valid <= s1_valid;
         s2_duck  <= s1_duck;
         s2_blank <= s1_blank;
         s2_x     <= s1_x;
         s2_y     <= s1_y;
         s2_bg    <= s1_bg;
      end
   end

   // Composite priority: blanking, transparency/background, flash, palette
   always_comb begin
      rgb_next = '0;
      if (!s2_valid || !s2_blank)
         rgb_next = '0;
      else if (!s2_duck || rom_data == TRANSP_IDX)
         rgb_next = s2_bg;
      else if (state == FLASH_ON)
         rgb_next = '1;
      else
         rgb_next = pal_rd;
   end

   // Output stage
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix_rgb   <= '0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_blank <= 1'b0;
      end else begin
         pix_rgb   <= rgb_next;
         pix_x     <= s2_x;
         pix_y     <= s2_y;
         pix_blank <= s2_valid & s2_blank;
      end
   end

endmodule

// File: doc/duck_pixel_reader.md
Name: duck_pixel_reader

Overview:
- Consumer end of the duck sprite address path.
- Takes the per-pixel sprite address and in-sprite flag from the duck position/animation block, reads the sprite index ROM (synchronous, 1-cycle read) and looks the index up in a writable 16-entry palette.
- Composites the result over a supplied background colour and emits a pipeline-aligned RGB pixel plus delayed DrawX/DrawY/blank to the VGA colour mapper.
- Also owns the "duck hit" white-flash effect.

Parameters:
- FLASH_PERIOD, 4, frame_clk rising edges per flash on/off phase.
- FLASH_FRAMES, 32, total frame_clk rising edges a flash lasts.
- TRANSP_IDX, 4'h0, palette index treated as transparent.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  frame strobe, ~60 Hz, asynchronous to nothing (same Clk domain, slow).
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- blank  in  1  1 = active video, 0 = blanking.
- is_duck  in  1  current pixel lies inside the duck sprite box.
- duck_addr  in  16  sprite ROM address for the current pixel.
- bg_rgb  in  24  background colour for the current pixel, {R,G,B}.
- rom_addr  out  16  registered address to the sprite index ROM.
- rom_data  in  4  palette index from ROM, valid one cycle after rom_addr.
- pal_we  in  1  palette write strobe.
- pal_idx  in  4  palette write index.
- pal_data  in  24  palette write colour.
- hit  in  1  one-cycle pulse: duck was shot, start flash.
- pix_rgb  out  24  composited output colour.
- pix_x  out  10  DrawX delayed to align with pix_rgb.
- pix_y  out  10  DrawY delayed to align with pix_rgb.
- pix_blank  out  1  blank delayed to align with pix_rgb.
- flashing  out  1  1 while the flash FSM is not IDLE.

Behaviour:
- Reset applies on a Clk edge with Reset=1.
  - All outputs go to 0: rom_addr, pix_rgb, pix_x, pix_y, pix_blank, flashing.
  - All pipeline valid bits clear, all 16 palette entries become 24'h000000, FSM goes to IDLE, frame counters clear.
- Pipeline, fixed latency 3: inputs presented in cycle n appear on pix_* in cycle n+3, with no bubbles and no stall.
  - End of cycle n: rom_addr <= duck_addr; s1 holds {is_duck & blank, DrawX, DrawY, blank, bg_rgb}.
  - End of cycle n+1: the ROM registers rom_data; s2 <= s1.
  - End of cycle n+2: output stage registers the composite of s2 and rom_data.
- rom_addr is updated every cycle, including blanking and non-duck pixels.
- Composite rule, evaluated in priority order:
  - s2.blank=0 -> pix_rgb = 0.
  - Otherwise, s2.duck=0 or rom_data==TRANSP_IDX -> pix_rgb = s2.bg_rgb.
  - Otherwise, FSM in FLASH_ON -> 24'hFFFFFF.
  - Otherwise -> palette[rom_data].
- Palette:
  - Written on any cycle with pal_we=1, including mid-frame.
  - If a write and a read of the same index coincide, the read returns the old value; the new value is visible from the next cycle.
- Frame edge: frame_clk is delayed one Clk, rising edge = frame_clk & ~delayed. The resulting pulse is registered, i.e. one Clk late.
- Flash FSM states: IDLE, FLASH_ON, FLASH_OFF.
  - In IDLE, hit=1 -> FLASH_ON, phase_cnt=0, total_cnt=0.
  - Each frame edge while not IDLE: phase_cnt++ and total_cnt++.
  - When phase_cnt reaches FLASH_PERIOD, toggle ON<->OFF and set phase_cnt=0.
  - When total_cnt reaches FLASH_FRAMES -> IDLE; this takes priority over the toggle.
  - hit while not IDLE restarts: FLASH_ON with both counters at 0.
  - hit coincident with a frame edge: the restart wins and the edge is not counted.
- flashing = (state != IDLE), registered, so it rises the cycle after the state leaves IDLE.
- Reset mid-flash: FSM goes to IDLE and flashing=0 on the next cycle.
- Reset mid-pipeline: in-flight pixels are discarded, and outputs are 0 until 3 cycles after Reset deasserts.
- Widths: counters are 6 bits. FLASH_FRAMES is limited to 63 or less and FLASH_PERIOD to 1 or more.

Test Plan:
- Reset then blank=1, is_duck=0, bg_rgb=24'h3CBCFC for 10 cycles -> pix_rgb=0 through cycle 2, then 24'h3CBCFC from cycle 3 on; pix_x/pix_y equal DrawX/DrawY delayed by 3.
- Write palette[5]=24'hA05000; drive is_duck=1, duck_addr=16'h0123, ROM model returns 4'h5 one cycle after rom_addr=16'h0123 -> rom_addr=16'h0123 in cycle n+1, pix_rgb=24'hA05000 in cycle n+3.
- Same stimulus but ROM returns 4'h0 -> pix_rgb = bg_rgb; same with blank=0 -> pix_rgb=0.
- Write palette[5] with 24'h00FF00 in the same cycle the stage-2 read of index 5 occurs -> that pixel outputs the old 24'hA05000, and the next pixel outputs 24'h00FF00.
- hit pulse, then 40 frame edges with an opaque duck pixel -> FLASH_ON (pix_rgb FFFFFF) for edges 0-3, palette colour for edges 4-7, alternating; flashing drops after the 32nd edge; hit at edge 10 restarts the count at 0.
- Assert Reset at edge 6 of a flash -> flashing=0 next cycle, and pix_rgb=0 for 3 cycles after release.
